neuron_mac_seq: RTL and testbench
=================================

// Module: neuron_mac_seq
// PURPOSE
//  Sequential multiply-accumulate front end of the neuron. Accepts N_INPUTS (x, w) pairs, 8-bit signed each, over a
//  valid/ready handshake and forms each product with an 8-cycle shift-add multiplier. Sums the products into a 16-bit
//  signed dot product. Drives that result downstream as the 16-bit accumulator operand of the bias adder/requantiser.
// PARAMETERS
//  N_INPUTS  4                   number of (x, w) terms per dot product; must be >= 1
//  CNT_W     $clog2(N_INPUTS+1)  width of the term counter
// PORTS
//  clk        in   1   rising-edge clock
//  rst_n      in   1   asynchronous active-low reset
//  in_valid   in   1   x_in/w_in hold a valid term
//  in_ready   out  1   block can accept a term; a term transfers when in_valid && in_ready
//  x_in       in   8   signed activation
//  w_in       in   8   signed weight
//  acc_valid  out  1   acc_out/ovf hold a completed dot product
//  acc_ready  in   1   downstream accepts; result transfers when acc_valid && acc_ready
//  acc_out    out  16  signed dot product, sum of x*w over N_INPUTS terms
//  ovf        out  1   sticky: 16-bit signed range was exceeded during this dot product
// BEHAVIOUR
//  Reset (async assert, sync deassert):
//   - state=IDLE; in_ready=1; acc_valid=0; acc_out=0; ovf=0.
//   - Term count, multiplier registers and accumulator are all cleared.
//   - Reset asserted in any state aborts that state immediately; any partial sum is discarded.
//  IDLE:
//   - in_ready=1.
//   - On a term transfer: latch |x| and |w| plus the product sign (x[7]^w[7]); go to MUL.
//   - |-128| is 128; the magnitude registers are 8-bit unsigned.
//  MUL (exactly 8 cycles, iteration counter 0..7):
//   - in_ready=0.
//   - Each cycle: if the current multiplier bit is set, add the shifted multiplicand to a 16-bit partial product.
//   - After iteration 7, negate the partial product if the sign bit is set; go to ACC.
//   - The product is a full signed integer with range [-16256, +16384]; it always fits in 16 bits signed.
//  ACC (1 cycle):
//   - Compute sum = sign-extended acc + product in 17 bits.
//   - Overflow when sum[16] != sum[15]; on overflow ovf<=1.
//   - The accumulator update on overflow depends on SATURATE_EN (see CONFIGURATION).
//   - Increment the term count. If count==N_INPUTS go to DONE, else go to IDLE.
//  DONE:
//   - acc_valid=1, in_ready=0.
//   - acc_out and ovf stay stable while acc_ready=0.
//   - On a result transfer, in the same edge: acc, count and ovf clear to 0, acc_valid<=0, state<=IDLE.
//     in_ready is 1 in the next cycle.
//  Latency and throughput:
//   - Term accepted at edge T: MUL covers T+1..T+8, ACC is T+9.
//   - in_ready or acc_valid rises after edge T+10.
//   - With in_valid held high, one term is accepted every 10 cycles.
//  Ordering and edge cases:
//   - acc_out is the registered accumulator; it also shows partial sums during accumulation. Consumers sample it only
//     when acc_valid=1.
//   - in_valid is ignored outside IDLE.
//   - in_ready and acc_valid are never both 1, so no input transfer can coincide with an output transfer.
//   - A product of 0, including any x=0 or w=0, still takes the full 10 cycles.
// CONFIGURATION
//  SATURATE_EN defined:
//   - On overflow, acc clamps to +32767 (sum>0) or -32768 (sum<0).
//   - Later terms accumulate from the clamped value.
//  SATURATE_EN undefined:
//   - On overflow, acc wraps: acc=sum[15:0] (two's complement).
//  In both builds, ovf is set on any overflow and stays set until the result transfer or reset.
// TESTING
//  All scenarios use N_INPUTS=4.
//  1 Basic: x={10,-3,127,-128}, w={2,5,1,-128} -> acc_out=16516 (0x4084), ovf=0.
//  2 Overflow: 4 terms of x=-128, w=-128 (sum 65536). Wrap build -> acc_out=0x0000, ovf=1.
//    SATURATE_EN build -> acc_out=32767, ovf=1.
//  3 Timing: in_valid held high, acc_ready=1, first transfer at edge 0 -> transfers at edges 0/10/20/30.
//    acc_valid high after edge 40 and drops after the result transfer. in_ready returns high after edge 41.
//  4 Backpressure:
//   - Hold acc_ready=0 for 5 cycles after acc_valid -> acc_out/ovf unchanged and in_ready=0 throughout.
//   - A new input sent during the hold is not accepted.
//  5 Reset mid-MUL: pulse rst_n low during term 3 MUL -> all outputs at reset values with no clock edge.
//    Next 4 terms x=1, w=1 -> acc_out=4, ovf=0.
//  6 Sign corners: pairs (-128,127),(127,-128),(-1,-1),(0,-128) -> acc_out=-32511 (0x8101), ovf=0.

Source files
------------

// File: rtl/neuron_mac_seq.sv
// Sequential MAC front end: N_INPUTS signed 8x8 products via an 8-cycle shift-add
// multiplier, summed into a 16-bit signed accumulator. Define SATURATE_EN to clamp on overflow.
module neuron_mac_seq #(
   parameter int N_INPUTS = 4,
   parameter int CNT_W    = $clog2(N_INPUTS + 1)
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [7:0]  x_in,
   input  logic [7:0]  w_in,
   output logic        acc_valid,
   input  logic        acc_ready,
   output logic [15:0] acc_out,
   output logic        ovf
);

   typedef enum logic [1:0] {IDLE, MUL, ACC, DONE} state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [15:0]      mcand_q, mcand_d;
   logic [7:0]       mplier_q, mplier_d;
   logic             sign_q, sign_d;
   logic [2:0]       iter_q, iter_d;
   logic [15:0]      pp_q, pp_d;
   logic [15:0]      acc_q, acc_d;
   logic             ovf_q, ovf_d;

   logic [7:0]       x_mag, w_mag;
   logic [15:0]      pp_add;
   logic [16:0]      sum;
   logic             sum_ovf;

   always_comb begin
      // |-128| = 128 still fits the 8-bit unsigned magnitude
      x_mag   = x_in[7] ? (~x_in + 8'd1) : x_in;
      w_mag   = w_in[7] ? (~w_in + 8'd1) : w_in;
      pp_add  = mplier_q[0] ? (pp_q + mcand_q) : pp_q;
      sum     = {acc_q[15], acc_q} + {pp_q[15], pp_q};
      sum_ovf = sum[16] ^ sum[15];
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      sign_d   = sign_q;
      iter_d   = iter_q;
      pp_d     = pp_q;
      acc_d    = acc_q;
      ovf_d    = ovf_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               mcand_d  = {8'h00, x_mag};
               mplier_d = w_mag;
               sign_d   = x_in[7] ^ w_in[7];
               pp_d     = 16'h0000;
               iter_d   = 3'd0;
               state_d  = MUL;
            end
         end
         MUL: begin
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            iter_d   = iter_q + 3'd1;
            pp_d     = pp_add;
            if (iter_q == 3'd7) begin
               pp_d    = sign_q ? (~pp_add + 16'd1) : pp_add;
               state_d = ACC;
            end
         end
         ACC: begin
            acc_d = sum[15:0];
            if (sum_ovf) begin
               ovf_d = 1'b1;
`ifdef SATURATE_EN
               acc_d = sum[16] ? 16'h8000 : 16'h7FFF;
`else
               acc_d = sum[15:0];
`endif
            end
            cnt_d   = cnt_q + 1'b1;
            state_d = (cnt_q == CNT_W'(N_INPUTS - 1)) ? DONE : IDLE;
         end
         DONE: begin
            if (acc_ready) begin
               acc_d   = 16'h0000;
               cnt_d   = '0;
               ovf_d   = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         mcand_q  <= 16'h0000;
         mplier_q <= 8'h00;
         sign_q   <= 1'b0;
         iter_q   <= 3'd0;
         pp_q     <= 16'h0000;
         acc_q    <= 16'h0000;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         sign_q   <= sign_d;
         iter_q   <= iter_d;
         pp_q     <= pp_d;
         acc_q    <= acc_d;
         ovf_q    <= ovf_d;
      end
   end

   // Handshake flags decode straight from the registered state
   assign in_ready  = (state_q == IDLE);
   assign acc_valid = (state_q == DONE);
   assign acc_out   = acc_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_neuron_mac_seq.sv
// Randomised bench for neuron_mac_seq with a transaction-level model of the dot product
// and its cycle timing; literal expectations pin both model and DUT on the worked examples.
module tb_neuron_mac_seq;
   localparam int N = 4;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              in_valid = 1'b0;
   logic              acc_ready = 1'b0;
   logic signed [7:0] x_in = '0;
   logic signed [7:0] w_in = '0;
   logic              in_ready, acc_valid, ovf;
   logic [15:0]       acc_out;

   int total = 0;
   int bad = 0;

   // Model: edges left before the pending product lands, terms summed, running sum, sticky overflow
   int m_wait, m_terms, m_sum, m_prod;
   bit m_done, m_ovf;

   int edge_no = 0;
   int xfer_log[$];
   int res_log[$];
   int first_av;
   int tx[N];
   int tw[N];
   bit dummy;

   always #5 clk = ~clk;

   neuron_mac_seq #(.N_INPUTS(N)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .x_in(x_in), .w_in(w_in),
      .acc_valid(acc_valid), .acc_ready(acc_ready), .acc_out(acc_out), .ovf(ovf)
   );

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_no);
      end
   endtask

   function automatic int rnd8();
      return int'($urandom_range(0, 255)) - 128;
   endfunction

   function automatic int add_term(input int s, input int p, output bit o);
      int r;
      r = s + p;
      o = (r > 32767) || (r < -32768);
      if (!o) return r;
`ifdef SATURATE_EN
      return (r > 0) ? 32767 : -32768;
`else
      r = (r + 262144) % 65536;
      if (r >= 32768) r = r - 65536;
      return r;
`endif
   endfunction

   task automatic model_reset();
      m_wait = 0; m_terms = 0; m_sum = 0; m_prod = 0; m_done = 0; m_ovf = 0;
   endtask

   task automatic check_outputs();
      chk("in_ready", int'(in_ready), int'(m_wait == 0 && !m_done));
      chk("acc_valid", int'(acc_valid), int'(m_done));
      if (m_wait == 0) begin
         chk("acc_out", int'($signed(acc_out)), m_sum);
         chk("ovf", int'(ovf), int'(m_ovf));
      end
   endtask

   // Called at a negedge: check, drive inputs, advance the model across the next posedge
   task automatic step(input bit v, input int x, input int w, input bit ar, output bit took);
      bit o;
      check_outputs();
      in_valid = v; x_in = 8'(x); w_in = 8'(w); acc_ready = ar;
      if (acc_valid && first_av < 0) first_av = edge_no;
      if (v && in_ready) xfer_log.push_back(edge_no);
      if (acc_valid && ar) res_log.push_back(edge_no);
      took = 0;
      if (m_done) begin
         if (ar) begin
            $display("result edge=%0d acc_out=%0d ovf=%0d", edge_no, $signed(acc_out), ovf);
            model_reset();
         end
      end else if (m_wait == 0) begin
         if (v) begin
            took = 1;
            m_prod = x * w;
            m_wait = 9;
            $display("term   edge=%0d x=%0d w=%0d", edge_no, x, w);
         end
      end else begin
         m_wait--;
         if (m_wait == 0) begin
            m_sum = add_term(m_sum, m_prod, o);
            m_ovf = m_ovf | o;
            m_terms++;
            if (m_terms == N) m_done = 1;
         end
      end
      @(negedge clk);
      edge_no++;
   endtask

   task automatic run_dot(input bit hold, input bit ar);
      int i;
      int cyc;
      bit v;
      bit took;
      i = 0;
      cyc = 0;
      while (!m_done && cyc < 400) begin
         v = (i < N) ? (hold || ($urandom_range(0, 1) == 1)) : ($urandom_range(0, 1) == 1);
         step(v, (i < N) ? tx[i] : rnd8(), (i < N) ? tw[i] : rnd8(), ar, took);
         if (took) i++;
         cyc++;
      end
      chk("dot_timeout", int'(m_done), 1);
   endtask

   task automatic pop();
      int cyc;
      cyc = 0;
      while (m_done && cyc < 50) begin
         step($urandom_range(0, 1) == 1, rnd8(), rnd8(), $urandom_range(0, 2) != 0, dummy);
         cyc++;
      end
      chk("pop_timeout", int'(m_done), 0);
   endtask

   task automatic load(input int x0, x1, x2, x3, w0, w1, w2, w3);
      tx[0] = x0; tx[1] = x1; tx[2] = x2; tx[3] = x3;
      tw[0] = w0; tw[1] = w1; tw[2] = w2; tw[3] = w3;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      int nx;
      int took_n;
      bit took;
      model_reset();
      first_av = -1;
      repeat (2) @(negedge clk);
      chk("rst_in_ready", int'(in_ready), 1);
      chk("rst_acc_valid", int'(acc_valid), 0);
      chk("rst_acc_out", int'(acc_out), 0);
      chk("rst_ovf", int'(ovf), 0);
      rst_n = 1'b1;

      // Basic dot product, gappy input
      load(10, -3, 127, -128, 2, 5, 1, -128);
      run_dot(0, 0);
      chk("basic_model", m_sum, 16516);
      chk("basic_acc", int'($signed(acc_out)), 16516);
      chk("basic_ovf", int'(ovf), 0);
      pop();

      // Overflow
      load(-128, -128, -128, -128, -128, -128, -128, -128);
      run_dot(1, 0);
`ifdef SATURATE_EN
      chk("ovf_model", m_sum, 32767);
      chk("ovf_acc", int'($signed(acc_out)), 32767);
`else
      chk("ovf_model", m_sum, 0);
      chk("ovf_acc", int'($signed(acc_out)), 0);
`endif
      chk("ovf_flag", int'(ovf), 1);
      pop();

      // Timing with in_valid and acc_ready held high
      load(3, 4, 5, 6, 7, 8, 9, 10);
      base = edge_no;
      xfer_log.delete();
      res_log.delete();
      first_av = -1;
      run_dot(1, 1);
      step(0, 0, 0, 1, took);
      chk("xfer_count", xfer_log.size(), 4);
      for (int k = 0; k < 4 && k < xfer_log.size(); k++)
         chk("xfer_edge", xfer_log[k] - base, 10 * k);
      chk("acc_valid_edge", first_av - base, 40);
      chk("result_edge", (res_log.size() > 0) ? res_log[0] - base : -1, 40);
      chk("in_ready_back", int'(in_ready), 1);
      chk("in_ready_edge", edge_no - base, 41);

      // Backpressure: result held, new input refused
      load(-7, 100, 0, 55, 9, -2, 77, -1);
      run_dot(0, 0);
      nx = xfer_log.size();
      repeat (5) step(1, rnd8(), rnd8(), 0, dummy);
      chk("bp_no_accept", xfer_log.size() - nx, 0);
      chk("bp_acc", int'($signed(acc_out)), -63 - 200 - 55);
      pop();

      // Reset in the middle of the third term's multiply
      load(10, -3, 127, -128, 2, 5, 1, -128);
      took_n = 0;
      while (took_n < 3) begin
         step(1, tx[took_n], tw[took_n], 0, took);
         if (took) took_n++;
      end
      repeat (3) step(0, 0, 0, 0, dummy);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_in_ready", int'(in_ready), 1);
      chk("mid_rst_acc_valid", int'(acc_valid), 0);
      chk("mid_rst_acc_out", int'(acc_out), 0);
      chk("mid_rst_ovf", int'(ovf), 0);
      #1;
      rst_n = 1'b1;
      model_reset();
      load(1, 1, 1, 1, 1, 1, 1, 1);
      run_dot(1, 0);
      chk("after_rst_acc", int'($signed(acc_out)), 4);
      chk("after_rst_ovf", int'(ovf), 0);
      pop();

      // Sign corners
      load(-128, 127, -1, 0, 127, -128, -1, -128);
      run_dot(0, 0);
      chk("sign_model", m_sum, -32511);
      chk("sign_acc", int'($signed(acc_out)), -32511);
      chk("sign_ovf", int'(ovf), 0);
      pop();

      // Random dot products, including large magnitudes that may overflow
      for (int r = 0; r < 12; r++) begin
         for (int k = 0; k < N; k++) begin
            tx[k] = rnd8();
            tw[k] = (r % 3 == 0) ? (($urandom_range(0, 1) == 1) ? 127 : -128) : rnd8();
         end
         run_dot($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
         pop();
      end
      repeat (3) step(0, 0, 0, 0, dummy);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
